// File: rtl/fifo_if.sv
// Byte-in / word-out FIFO handshake and status bundle.
// Producer/consumer side is the master; the FIFO itself is the slave.
interface fifo_if;
  logic        wr_req;
  logic [7:0]  wr_data;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        wr_empty;
  logic        wr_full;
  logic [8:0]  wr_usedw;
  logic        rd_empty;
  logic        rd_full;
  logic [7:0]  rd_usedw;

  modport master (
    output wr_req, wr_data, rd_req,
    input  rd_data, wr_empty, wr_full, wr_usedw, rd_empty, rd_full, rd_usedw
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output rd_data, wr_empty, wr_full, wr_usedw, rd_empty, rd_full, rd_usedw
  );
endinterface

// File: rtl/fifo.sv
// 256-byte single-clock FIFO: 8-bit writes, 16-bit registered reads (older byte in [7:0]).
// All status flags decode from one 9-bit byte count.
module fifo (
  input logic   sys_clk,
  input logic   sys_rst_n,
  fifo_if.slave bus
);
  logic [7:0]  mem [0:255];
  logic [7:0]  wr_ptr, rd_ptr, rd_ptr_p1;
  logic [8:0]  cnt, cnt_nxt;
  logic [15:0] rd_q;
  logic        full, word_avail, wr_ok, rd_ok;

  assign full       = (cnt == 9'd256);
  assign word_avail = (cnt >= 9'd2);
  assign wr_ok      = bus.wr_req & ~full;
  assign rd_ok      = bus.rd_req & word_avail;
  assign rd_ptr_p1  = rd_ptr + 8'd1;

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + 9'd1;
      2'b01:   cnt_nxt = cnt - 9'd2;
      2'b11:   cnt_nxt = cnt - 9'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rd_q   <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 8'd1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 8'd2;
        rd_q   <= {mem[rd_ptr_p1], mem[rd_ptr]};
      end
      cnt <= cnt_nxt;
    end
  end

  // Storage is not cleared on reset; the count alone defines what is valid.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && wr_ok) mem[wr_ptr] <= bus.wr_data;
  end

  assign bus.rd_data  = rd_q;
  assign bus.wr_empty = (cnt == 9'd0);
  assign bus.wr_full  = full;
  assign bus.wr_usedw = cnt;
  assign bus.rd_empty = ~word_avail;
  assign bus.rd_full  = full;
  assign bus.rd_usedw = cnt[8:1];
endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: byte-queue reference model, a vector table for the odd-byte
// and simultaneous cases, fill/drain/wrap/reset sequences and a random soak.
module tb_fifo;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  fifo_if bus();
  fifo dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));

  always #5 sys_clk = ~sys_clk;

  logic [7:0]  q[$];
  logic [15:0] m_rd = 16'h0000;

  typedef struct {
    logic        wr;
    logic [7:0]  wd;
    logic        rd;
    logic [8:0]  e_used;
    logic [15:0] e_rd;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ":rd_data"},  32'(bus.rd_data),  32'(m_rd));
    chk({tag, ":wr_usedw"}, 32'(bus.wr_usedw), 32'(n));
    chk({tag, ":rd_usedw"}, 32'(bus.rd_usedw), 32'(n / 2));
    chk({tag, ":wr_empty"}, 32'(bus.wr_empty), 32'(n == 0));
    chk({tag, ":wr_full"},  32'(bus.wr_full),  32'(n == 256));
    chk({tag, ":rd_empty"}, 32'(bus.rd_empty), 32'(n < 2));
    chk({tag, ":rd_full"},  32'(bus.rd_full),  32'(n == 256));
  endtask

  // One clock with the given requests; model acceptance uses pre-edge occupancy.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string tag);
    logic wacc, racc;
    logic [7:0] b0, b1;
    wacc = w && (q.size() < 256);
    racc = r && (q.size() >= 2);
    bus.wr_req = w; bus.wr_data = d; bus.rd_req = r;
    if (racc) begin
      b0 = q.pop_front();
      b1 = q.pop_front();
      m_rd = {b1, b0};
    end
    if (wacc) q.push_back(d);
    @(posedge sys_clk); #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    check_all(tag);
  endtask

  // Reset with requests asserted; they must be ignored.
  task automatic do_reset(input int n, input string tag);
    sys_rst_n = 1'b0;
    bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.wr_data = 8'hC3;
    repeat (n) @(posedge sys_clk);
    #1;
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    q.delete();
    m_rd = 16'h0000;
    chk({tag, ":rst_usedw"}, 32'(bus.wr_usedw), 32'd0);
    chk({tag, ":rst_rd_data"}, 32'(bus.rd_data), 32'h0000);
    check_all(tag);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_data = 8'h00;

    // Odd leftover byte, ignored read, read/write pairs with count 1 and 2.
    vecs[0] = '{1'b1, 8'h55, 1'b0, 9'd1, 16'h0000};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 9'd1, 16'h0000};
    vecs[2] = '{1'b1, 8'h66, 1'b0, 9'd2, 16'h0000};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 9'd0, 16'h6655};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 9'd0, 16'h6655};
    vecs[5] = '{1'b1, 8'h01, 1'b0, 9'd1, 16'h6655};
    vecs[6] = '{1'b1, 8'h02, 1'b1, 9'd2, 16'h6655};
    vecs[7] = '{1'b1, 8'h03, 1'b1, 9'd1, 16'h0201};

    do_reset(2, "reset");
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].wr, vecs[i].wd, vecs[i].rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d:usedw", i), 32'(bus.wr_usedw), 32'(vecs[i].e_used));
      chk($sformatf("vec%0d:rd_data", i), 32'(bus.rd_data), 32'(vecs[i].e_rd));
    end

    // Fill to 256, then an overflow attempt.
    do_reset(1, "fill_rst");
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 1'b0, "fill");
    chk("fill:full", 32'({bus.wr_full, bus.rd_full}), 32'h3);
    chk("fill:usedw", 32'({bus.wr_usedw, bus.rd_usedw}), {15'd0, 9'd256, 8'd128});
    cyc(1'b1, 8'hAA, 1'b0, "overflow");
    chk("overflow:usedw", 32'(bus.wr_usedw), 32'd256);

    // Drain: word i is {2i+1, 2i}.
    for (int i = 0; i < 128; i++) begin
      cyc(1'b0, 8'h00, 1'b1, "drain");
      chk($sformatf("drain%0d", i), 32'(bus.rd_data), 32'({8'(2*i+1), 8'(2*i)}));
    end
    chk("drain:empty", 32'({bus.wr_empty, bus.rd_empty}), 32'h3);
    cyc(1'b0, 8'h00, 1'b1, "underflow");
    chk("underflow:rd_data", 32'(bus.rd_data), 32'hFFFE);

    // Simultaneous read+write with 10 stored.
    do_reset(1, "simul_rst");
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, "simul_fill");
    cyc(1'b1, 8'hEE, 1'b1, "simul");
    chk("simul:wr_usedw", 32'(bus.wr_usedw), 32'd9);
    chk("simul:rd_usedw", 32'(bus.rd_usedw), 32'd4);
    chk("simul:rd_data", 32'(bus.rd_data), 32'h1110);

    // Wrap: 200 in, 100 words out, 100 more in, then drain with order check.
    do_reset(1, "wrap_rst");
    for (int i = 0; i < 200; i++) cyc(1'b1, 8'($urandom), 1'b0, "wrap_w1");
    for (int i = 0; i < 100; i++) cyc(1'b0, 8'h00, 1'b1, "wrap_r1");
    chk("wrap:mid_usedw", 32'(bus.wr_usedw), 32'd0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 8'($urandom), 1'b0, "wrap_w2");
    for (int i = 0; i < 30; i++) cyc(1'b0, 8'h00, 1'b1, "wrap_r2");
    do_reset(1, "midstream_rst");
    chk("midstream:rd_empty", 32'(bus.rd_empty), 32'd1);

    // Random soak, alternating fill-biased and drain-biased phases.
    for (int ph = 0; ph < 8; ph++) begin
      int pw;
      pw = (ph % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 999) == 0) do_reset(1, "rnd_rst");
        else cyc($urandom_range(0, 99) < pw, 8'($urandom),
                 $urandom_range(0, 99) < 100 - pw, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The block SHALL be single-clock: all state SHALL update on the rising edge of sys_clk; reset sys_rst_n SHALL be synchronous and active-low.
REQ-002 sys_clk  input  1  system clock; the only clock, driving both write and read sides.
REQ-003 sys_rst_n  input  1  synchronous active-low reset.
REQ-004 wr_req  input  1  write request; one byte per cycle while high.
REQ-005 wr_data  input  8  write byte.
REQ-006 rd_req  input  1  read request; one 16-bit word per cycle while high.
REQ-007 rd_data  output  16  read word (registered).
REQ-008 wr_empty  output  1  byte count == 0.
REQ-009 wr_full  output  1  byte count == 256.
REQ-010 wr_usedw  output  9  stored bytes, 0..256.
REQ-011 rd_empty  output  1  stored bytes < 2 (no complete word).
REQ-012 rd_full  output  1  byte count == 256 (128 words).
REQ-013 rd_usedw  output  8  complete words stored = byte count / 2 (floor), 0..128.

Function
REQ-014 Storage SHALL be 256 bytes; write side 8 bits wide, read side 16 bits wide (128 words).
REQ-015 Internal byte count SHALL be 9-bit register; all status outputs SHALL be combinational decodes of it, so they reflect an accepted request the cycle after it.
REQ-016 Write accepted when wr_req=1 and wr_full=0; byte stored at write pointer, write pointer +1 modulo 256.
REQ-017 wr_req while wr_full=1 SHALL be ignored: no storage change, count unchanged, no overflow.
REQ-018 Read accepted when rd_req=1 and rd_empty=0; the two oldest bytes removed, read pointer +2 modulo 256.
REQ-019 Byte order: older byte SHALL appear on rd_data[7:0], newer byte on rd_data[15:8].
REQ-020 Read latency: rd_data SHALL update on the clock edge that accepts the read (valid the cycle after rd_req sampled), normal (non-show-ahead) mode.
REQ-021 rd_data SHALL hold its last value when no read is accepted, including rd_req while rd_empty=1 (ignored, no underflow).
REQ-022 Simultaneous accepted write and read in one cycle: count SHALL change by +1-2 = -1; both pointers advance; acceptance judged on pre-edge flags.
REQ-023 Pointers SHALL wrap seamlessly; data order SHALL be preserved across wrap.
REQ-024 A single leftover byte (odd count) SHALL remain stored and unreadable until a second byte is written; rd_usedw=0, rd_empty=1 in that state.

Reset
REQ-025 While sys_rst_n=0 at a rising edge: pointers and count SHALL clear to 0, rd_data SHALL be 16'h0000, outputs SHALL read wr_empty=1, wr_full=0, wr_usedw=0, rd_empty=1, rd_full=0, rd_usedw=0.
REQ-026 Reset mid-operation SHALL discard all stored data; requests during reset SHALL be ignored; memory contents need not be cleared.

Verification
REQ-027 Reset: hold sys_rst_n=0 two cycles -> rd_data=16'h0000, wr_empty=1, rd_empty=1, wr_usedw=0, rd_usedw=0, full flags 0.
REQ-028 Fill: write bytes 0..255 consecutively -> wr_full=1, rd_full=1, wr_usedw=256, rd_usedw=128; extra write of 8'hAA ignored, count stays 256.
REQ-029 Drain: from full, hold rd_req 128 cycles -> rd_data sequence 16'h0100, 16'h0302, ... 16'hFFFE one cycle after each request; then rd_empty=1, wr_empty=1, further rd_req leaves rd_data=16'hFFFE.
REQ-030 Odd byte: after reset write one byte 8'h55 -> wr_usedw=1, rd_usedw=0, rd_empty=1, wr_empty=0; rd_req ignored; write 8'h66 -> rd_usedw=1; read returns 16'h6655.
REQ-031 Simultaneous: with 10 bytes stored, assert wr_req and rd_req one cycle -> wr_usedw=9, rd_usedw=4, oldest two bytes returned.
REQ-032 Wrap/reset: write 200, read 100 words, write 100 more -> order intact across pointer wrap; assert reset mid-stream -> all counts 0 next cycle, rd_empty=1.
